// File: rtl/adc_result_buffer.sv
// adc_result_buffer: captures SAR converter results one cycle after each
// conversion-complete rise, optionally box-car averages them, and queues
// the results in a first-word-fall-through FIFO with a valid/ready output.
module adc_result_buffer #(
  parameter int DEPTH_LOG2 = 3,
  parameter int AVG_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  conv_done,
  input  logic [7:0]            conv_data,
  input  logic                  avg_en,
  input  logic                  out_ready,
  input  logic                  clr_ovf,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic                  done_prev;
  logic                  cap_pending;
  logic                  res_push;
  logic [7:0]            res_data;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  pop;
  logic                  do_push;
  logic                  drop;

  // Rise detect on conv_done; the sample is taken the cycle after the rise,
  // once the converter's result register has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_prev   <= 1'b0;
      cap_pending <= 1'b0;
    end else begin
      done_prev   <= conv_done;
      cap_pending <= conv_done & ~done_prev;
    end
  end

  generate
    if (AVG_LOG2 == 0) begin : g_no_avg
      assign res_push = cap_pending;
      assign res_data = conv_data;
    end else begin : g_avg
      localparam int ACC_W = 8 + AVG_LOG2;

      logic                avg_en_prev;
      logic [ACC_W-1:0]    acc;
      logic [ACC_W-1:0]    acc_sum;
      logic [AVG_LOG2-1:0] cnt;
      logic                mode_change;
      logic                win_last;

      assign mode_change = avg_en ^ avg_en_prev;
      assign acc_sum     = acc + ACC_W'(conv_data);
      // A sample arriving on a mode change starts a fresh window, so it can
      // never be the closing sample of one.
      assign win_last    = (&cnt) & ~mode_change;
      assign res_push    = cap_pending & (~avg_en | win_last);
      assign res_data    = avg_en ? acc_sum[ACC_W-1:AVG_LOG2] : conv_data;

      // Window accumulator; any avg_en change throws away a partial window.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          avg_en_prev <= 1'b0;
          acc         <= '0;
          cnt         <= '0;
        end else begin
          avg_en_prev <= avg_en;
          if (cap_pending && avg_en) begin
            if (mode_change) begin
              acc <= ACC_W'(conv_data);
              cnt <= AVG_LOG2'(1);
            end else if (win_last) begin
              acc <= '0;
              cnt <= '0;
            end else begin
              acc <= acc_sum;
              cnt <= cnt + AVG_LOG2'(1);
            end
          end else if (mode_change) begin
            acc <= '0;
            cnt <= '0;
          end
        end
      end
    end
  endgenerate

  assign full       = (count == CNT_W'(DEPTH));
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign do_push    = res_push & (~full | pop);
  assign drop       = res_push & full & ~pop;
  assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count = count;

  // Storage array; contents need no reset because out_data is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= res_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({do_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_result_buffer.sv
// tb_adc_result_buffer: randomized and directed stimulus with a scoreboard
// queue filled by a behavioural model and drained by a handshake monitor.
module tb_adc_result_buffer;

  localparam int DEPTH_LOG2 = 3;
  localparam int AVG_LOG2   = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int WIN        = 1 << AVG_LOG2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              conv_done;
  logic [7:0]        conv_data;
  logic              avg_en;
  logic              out_ready;
  logic              clr_ovf;
  logic [7:0]        out_data;
  logic              out_valid;
  logic [DEPTH_LOG2:0] fifo_count;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         win[$];
  logic       model_ovf = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic       stim_done;

  adc_result_buffer #(.DEPTH_LOG2(DEPTH_LOG2), .AVG_LOG2(AVG_LOG2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .conv_done  (conv_done),
    .conv_data  (conv_data),
    .avg_en     (avg_en),
    .out_ready  (out_ready),
    .clr_ovf    (clr_ovf),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: a result enters the queue if there is room, otherwise it is lost
  function automatic void model_push(input logic [7:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else model_ovf = 1'b1;
  endfunction

  // Reference: plain mean of each complete window, truncated
  function automatic void model_sample(input logic [7:0] d);
    int s;
    if (!avg_en || AVG_LOG2 == 0) begin
      model_push(d);
    end else begin
      win.push_back(int'(d));
      if (win.size() == WIN) begin
        s = 0;
        foreach (win[i]) s += win[i];
        model_push(8'(s / WIN));
        win.delete();
      end
    end
  endfunction

  // One conversion: done high for 'hold' cycles, then low for one cycle
  task automatic apply_stimulus(input logic [7:0] data, input int hold);
    conv_done = 1'b1;
    conv_data = data;
    model_sample(data);
    for (int i = 0; i < hold; i++) tick();
    conv_done = 1'b0;
    tick();
  endtask

  task automatic set_avg(input logic en);
    avg_en = en;
    win.delete();
    tick();
    tick();
  endtask

  task automatic drain_fifo(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 64) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check_output(name, 32'(fifo_count), 32'd0);
  endtask

  // Scoreboard monitor: compares every handshake and checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!out_valid || out_data !== stall_data) begin
          errors++;
          $display("[TB] FAIL stall_stable: got valid=%0b data=0x%0h, expected valid=1 data=0x%0h",
                   out_valid, out_data, stall_data);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL pop_data: got 0x%0h, expected no output", out_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("[TB] FAIL pop_data: got 0x%0h, expected 0x%0h", out_data, e);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  // Global time bound
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus sequence
  initial begin
    rst_n     = 1'b0;
    conv_done = 1'b0;
    conv_data = 8'h00;
    avg_en    = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    stim_done = 1'b0;
    repeat (3) tick();
    check_output("rst_valid", 32'(out_valid), 32'd0);
    check_output("rst_count", 32'(fifo_count), 32'd0);
    check_output("rst_ovf",   32'(overflow), 32'd0);
    check_output("rst_data",  32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic pass-through with latency 2
    conv_done = 1'b1;
    conv_data = 8'hA5;
    model_sample(8'hA5);
    tick();
    conv_done = 1'b0;
    check_output("lat_n1_valid", 32'(out_valid), 32'd0);
    tick();
    check_output("lat_n2_valid", 32'(out_valid), 32'd1);
    check_output("lat_n2_data",  32'(out_data), 32'hA5);
    check_output("lat_n2_count", 32'(fifo_count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("pop_valid", 32'(out_valid), 32'd0);

    // Held done gives one capture
    apply_stimulus(8'h3C, 4);
    tick();
    check_output("held_count", 32'(fifo_count), 32'd1);
    drain_fifo("held_drain");

    // Averaging window
    set_avg(1'b1);
    apply_stimulus(8'h10, 1);
    check_output("avg_s1_count", 32'(fifo_count), 32'd0);
    apply_stimulus(8'h20, 1);
    check_output("avg_s2_count", 32'(fifo_count), 32'd0);
    apply_stimulus(8'h30, 1);
    check_output("avg_s3_count", 32'(fifo_count), 32'd0);
    apply_stimulus(8'h41, 1);
    check_output("avg_valid", 32'(out_valid), 32'd1);
    check_output("avg_data",  32'(out_data), 32'h28);
    check_output("avg_count", 32'(fifo_count), 32'd1);
    drain_fifo("avg_drain");

    // Partial window discarded by a mode toggle
    apply_stimulus(8'h80, 1);
    apply_stimulus(8'h90, 1);
    set_avg(1'b0);
    set_avg(1'b1);
    check_output("toggle_count", 32'(fifo_count), 32'd0);
    for (int i = 0; i < 4; i++) apply_stimulus(8'($urandom_range(0, 255)), 1);
    tick();
    check_output("fresh_count", 32'(fifo_count), 32'd1);
    drain_fifo("fresh_drain");
    set_avg(1'b0);

    // Fill past full
    for (int i = 1; i <= 9; i++) apply_stimulus(8'(i), 1);
    tick();
    check_output("full_count", 32'(fifo_count), 32'd8);
    check_output("full_ovf",   32'(overflow), 32'(model_ovf));
    drain_fifo("full_drain");
    check_output("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    model_ovf = 1'b0;
    check_output("ovf_clear", 32'(overflow), 32'd0);

    // Push and pop coincide while full
    for (int i = 0; i < 8; i++) apply_stimulus(8'(8'h11 + i), 1);
    tick();
    check_output("refill_count", 32'(fifo_count), 32'd8);
    conv_done = 1'b1;
    conv_data = 8'h99;
    exp_q.push_back(8'h99);
    tick();
    conv_done = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("pp_count", 32'(fifo_count), 32'd8);
    check_output("pp_ovf",   32'(overflow), 32'd0);
    drain_fifo("pp_drain");

    // Random back-pressure across pointer wrap
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          apply_stimulus(8'($urandom_range(0, 255)), $urandom_range(1, 3));
          repeat ($urandom_range(0, 2)) tick();
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    tick();
    tick();
    drain_fifo("rand_drain");
    check_output("rand_ovf",   32'(overflow), 32'(model_ovf));
    check_output("rand_left",  32'(exp_q.size()), 32'd0);

    // Async reset with entries queued and a partial window
    for (int i = 0; i < 5; i++) apply_stimulus(8'(8'h50 + i), 1);
    set_avg(1'b1);
    apply_stimulus(8'h60, 1);
    apply_stimulus(8'h61, 1);
    tick();
    check_output("pre_rst_count", 32'(fifo_count), 32'd5);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    win.delete();
    model_ovf = 1'b0;
    #1;
    check_output("arst_valid", 32'(out_valid), 32'd0);
    check_output("arst_count", 32'(fifo_count), 32'd0);
    check_output("arst_data",  32'(out_data), 32'd0);
    check_output("arst_ovf",   32'(overflow), 32'd0);
    avg_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    conv_done = 1'b1;
    conv_data = 8'h77;
    model_sample(8'h77);
    tick();
    conv_done = 1'b0;
    check_output("post_n1_valid", 32'(out_valid), 32'd0);
    tick();
    check_output("post_n2_valid", 32'(out_valid), 32'd1);
    check_output("post_n2_data",  32'(out_data), 32'h77);
    check_output("post_n2_count", 32'(fifo_count), 32'd1);
    drain_fifo("post_drain");
    check_output("final_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
